// File: rtl/mvm_stream.sv
// mvm_stream: streaming matrix-vector multiplier, y = A * x.
//
// A (M x N, signed B-bit) and x (N entries) are loaded serially through
// data_in and kept in on-chip memories. P MAC lanes then compute the rows,
// with lane l owning rows l, l+P, l+2P, ... Results land in an M-entry buffer
// and are streamed out on data_out under a valid/ready handshake.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   load_matrix          pulse in IDLE: load M*N words of A, row-major
//   load_vector          pulse in IDLE: load N words of x
//   start                pulse in IDLE: compute (needs A and x loaded)
//   data_in_valid/data_in  serial input word, gaps allowed
//   busy                 high in every state except IDLE
//   out_valid/out_ready/data_out  result stream y[0..M-1]
//   done                 one-cycle pulse after y[M-1] is accepted
//
// Optional build macro MVM_RELU_EN: clamps negative results to zero as they
// are written into the output buffer (no latency change).
module mvm_stream #(
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int B     = 8,
  parameter int P     = 2,
  parameter int G     = 1,
  parameter int ACC_W = 2*B + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_matrix,
  input  logic                    load_vector,
  input  logic                    start,
  input  logic                    data_in_valid,
  input  logic signed [B-1:0]     data_in,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] data_out,
  output logic                    done
);
  localparam int RG = M / P;          // row groups
  localparam int AD = RG * N;         // words per lane bank of A
  localparam int CT = AD + G + 1;     // COMPUTE cycles
  localparam int AW = (AD > 1) ? $clog2(AD) : 1;
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (RG > 1) ? $clog2(RG) : 1;
  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam int CW = $clog2(CT);

  localparam logic [XW-1:0] COL_LAST   = XW'(N - 1);
  localparam logic [GW-1:0] GRP_LAST   = GW'(RG - 1);
  localparam logic [LW-1:0] LANE_LAST  = LW'(P - 1);
  localparam logic [AW-1:0] ROW_REWIND = AW'(N - 1);
  localparam logic [CW-1:0] RD_END     = CW'(AD);
  localparam logic [CW-1:0] CMP_LAST   = CW'(CT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, DRAIN} state_t;
  state_t state_reg, state_next;

  // A is banked per lane so every lane reads its own row each cycle.
  logic signed [B-1:0]     a_mem [P][AD];
  logic signed [B-1:0]     x_mem [N];
  logic signed [ACC_W-1:0] y_mem [P][RG];

  logic          m_loaded, v_loaded;
  logic [XW-1:0] ld_col;
  logic [LW-1:0] ld_lane;
  logic [GW-1:0] ld_grp;
  logic [AW-1:0] ld_addr;
  logic [CW-1:0] cmp_cnt;
  logic [AW-1:0] rd_addr;
  logic [XW-1:0] rd_col;
  logic [GW-1:0] rd_grp;
  logic [LW-1:0] out_lane, nxt_lane;
  logic [GW-1:0] out_grp, nxt_grp;
  logic          rd_en, ld_m_last, ld_v_last, out_last;

  logic signed [B-1:0] x_q;
  logic                s1_valid, s1_first, s1_last;
  logic [GW-1:0]       s1_grp;
  logic                acc_valid, acc_first, acc_last;
  logic [GW-1:0]       acc_grp;
  logic signed [ACC_W-1:0] lane_res [P];

  assign ld_m_last = data_in_valid && (ld_col == COL_LAST) &&
                     (ld_lane == LANE_LAST) && (ld_grp == GRP_LAST);
  assign ld_v_last = data_in_valid && (ld_col == COL_LAST);
  assign rd_en     = (state_reg == COMPUTE) && (cmp_cnt < RD_END);
  assign out_last  = (out_lane == LANE_LAST) && (out_grp == GRP_LAST);

  always_comb begin
    nxt_lane = out_lane + 1'b1;
    nxt_grp  = out_grp;
    if (out_lane == LANE_LAST) begin
      nxt_lane = '0;
      nxt_grp  = out_grp + 1'b1;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (load_matrix)                           state_next = LOAD_M;
        else if (load_vector)                      state_next = LOAD_V;
        else if (start && m_loaded && v_loaded)    state_next = COMPUTE;
      end
      LOAD_M:  if (ld_m_last) state_next = IDLE;
      LOAD_V:  if (ld_v_last) state_next = IDLE;
      COMPUTE: if (cmp_cnt == CMP_LAST) state_next = DRAIN;
      DRAIN:   if (out_ready && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    out_valid = (state_reg == DRAIN);
  end

  // ---------------- control counters and output register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      m_loaded <= 1'b0;  v_loaded <= 1'b0;
      ld_col   <= '0;    ld_lane  <= '0;  ld_grp <= '0;  ld_addr <= '0;
      cmp_cnt  <= '0;    rd_addr  <= '0;  rd_col <= '0;  rd_grp  <= '0;
      out_lane <= '0;    out_grp  <= '0;
      done     <= 1'b0;  data_out <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          ld_col   <= '0;  ld_lane <= '0;  ld_grp <= '0;  ld_addr <= '0;
          cmp_cnt  <= '0;  rd_addr <= '0;  rd_col <= '0;  rd_grp  <= '0;
          out_lane <= '0;  out_grp <= '0;
          // A partially overwritten buffer is not a valid operand.
          if (load_matrix)      m_loaded <= 1'b0;
          else if (load_vector) v_loaded <= 1'b0;
        end
        LOAD_M: if (data_in_valid) begin
          if (ld_col == COL_LAST) begin
            ld_col <= '0;
            if (ld_lane == LANE_LAST) begin
              // next row belongs to lane 0 of the next group
              ld_lane <= '0;
              ld_grp  <= ld_grp + 1'b1;
              ld_addr <= ld_addr + 1'b1;
              if (ld_grp == GRP_LAST) m_loaded <= 1'b1;
            end else begin
              // next row goes to the next lane at the same group base
              ld_lane <= ld_lane + 1'b1;
              ld_addr <= ld_addr - ROW_REWIND;
            end
          end else begin
            ld_col  <= ld_col + 1'b1;
            ld_addr <= ld_addr + 1'b1;
          end
        end
        LOAD_V: if (data_in_valid) begin
          if (ld_col == COL_LAST) begin
            ld_col   <= '0;
            v_loaded <= 1'b1;
          end else begin
            ld_col <= ld_col + 1'b1;
          end
        end
        COMPUTE: begin
          cmp_cnt <= cmp_cnt + 1'b1;
          if (rd_en) begin
            rd_addr <= rd_addr + 1'b1;
            if (rd_col == COL_LAST) begin
              rd_col <= '0;
              rd_grp <= rd_grp + 1'b1;
            end else begin
              rd_col <= rd_col + 1'b1;
            end
          end
          // y[0] may be written on this very edge when there is one group
          if (cmp_cnt == CMP_LAST)
            data_out <= (acc_valid && acc_last && acc_grp == '0) ? lane_res[0]
                                                                 : y_mem[0][0];
        end
        DRAIN: if (out_ready) begin
          if (out_last) begin
            done <= 1'b1;
          end else begin
            out_lane <= nxt_lane;
            out_grp  <= nxt_grp;
            data_out <= y_mem[nxt_lane][nxt_grp];
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- memories ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_reg == LOAD_M && data_in_valid) a_mem[ld_lane][ld_addr] <= data_in;
      if (state_reg == LOAD_V && data_in_valid) x_mem[ld_col] <= data_in;
      for (int l = 0; l < P; l++)
        if (acc_valid && acc_last) y_mem[l][acc_grp] <= lane_res[l];
    end
  end

  // ---------------- shared pipeline tags ----------------
  always_ff @(posedge clk) begin
    x_q      <= x_mem[rd_col];
    s1_first <= (rd_col == '0);
    s1_last  <= (rd_col == COL_LAST);
    s1_grp   <= rd_grp;
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= rd_en;
  end

  generate
    if (G == 1) begin : g_tag_piped
      always_ff @(posedge clk) begin
        acc_first <= s1_first;
        acc_last  <= s1_last;
        acc_grp   <= s1_grp;
        if (reset) acc_valid <= 1'b0;
        else       acc_valid <= s1_valid;
      end
    end else begin : g_tag_direct
      assign acc_valid = s1_valid;
      assign acc_first = s1_first;
      assign acc_last  = s1_last;
      assign acc_grp   = s1_grp;
    end
  endgenerate

  // ---------------- MAC lanes ----------------
  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    logic signed [B-1:0]     a_q;
    logic signed [2*B-1:0]   prod;
    logic signed [ACC_W-1:0] term, acc_reg, acc_sum;

    always_ff @(posedge clk) a_q <= a_mem[gi][rd_addr];

    assign prod = (2*B)'(a_q) * (2*B)'(x_q);

    if (G == 1) begin : g_preg
      logic signed [2*B-1:0] prod_reg;
      always_ff @(posedge clk) prod_reg <= prod;
      assign term = ACC_W'(prod_reg);
    end else begin : g_pcomb
      assign term = ACC_W'(prod);
    end

    // first column of a row restarts the sum instead of adding to it
    assign acc_sum = acc_first ? term : acc_reg + term;

    always_ff @(posedge clk) begin
      if (reset)          acc_reg <= '0;
      else if (acc_valid) acc_reg <= acc_sum;
    end

`ifdef MVM_RELU_EN
    assign lane_res[gi] = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
    assign lane_res[gi] = acc_sum;
`endif
  end

endmodule

// File: tb/tb_mvm_stream.sv
// Directed testbench for mvm_stream (M=8, N=8, B=8, P=2, G=1).
module tb_mvm_stream;
  localparam int M = 8, N = 8, B = 8, P = 2, G = 1;
  localparam int ACC_W = 2*B + $clog2(N);

  logic clk = 1'b0;
  logic reset, load_matrix, load_vector, start, data_in_valid, out_ready;
  logic signed [B-1:0]     data_in;
  logic busy, out_valid, done;
  logic signed [ACC_W-1:0] data_out;

  int checks = 0;
  int failures = 0;

  logic signed [B-1:0] amat [M*N];
  logic signed [B-1:0] xvec [N];
  longint              exp_y [M];

  always #5 clk = ~clk;

  mvm_stream #(.M(M), .N(N), .B(B), .P(P), .G(G)) dut (
    .clk(clk), .reset(reset),
    .load_matrix(load_matrix), .load_vector(load_vector), .start(start),
    .data_in_valid(data_in_valid), .data_in(data_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .done(done)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input bit gapped, input bit with_start);
    load_matrix = 1'b1; start = with_start;
    data_in_valid = 1'b1; data_in = 8'sd99;     // not a data word
    tick();
    load_matrix = 1'b0; start = 1'b0;
    chk("load_m_busy", longint'(busy), 1);
    for (int k = 0; k < M*N; k++) begin
      if (gapped && (k % 2 == 1)) begin
        data_in_valid = 1'b0; data_in = 8'sd77;
        tick();
      end
      data_in_valid = 1'b1; data_in = amat[k];
      if (k == N || k == M*N-1) chk("load_m_mid_busy", longint'(busy), 1);
      tick();
    end
    data_in_valid = 1'b0;
    chk("load_m_end_idle", longint'(busy), 0);
    $display("loaded A gapped=%0d with_start=%0d", gapped, with_start);
  endtask

  task automatic load_x(input bit gapped);
    load_vector = 1'b1; data_in_valid = 1'b1; data_in = 8'sd99;
    tick();
    load_vector = 1'b0;
    chk("load_v_busy", longint'(busy), 1);
    for (int k = 0; k < N; k++) begin
      if (gapped && (k % 2 == 1)) begin
        data_in_valid = 1'b0; data_in = 8'sd77;
        tick();
      end
      data_in_valid = 1'b1; data_in = xvec[k];
      tick();
    end
    data_in_valid = 1'b0;
    chk("load_v_end_idle", longint'(busy), 0);
    $display("loaded x gapped=%0d", gapped);
  endtask

  task automatic run(input int stall);
    int cyc;
    out_ready = (stall == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy", longint'(busy), 1);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("compute_cycles", longint'(cyc), 34);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", longint'(out_valid), 1);
      chk("stall_hold", longint'(data_out), exp_y[0]);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < M; i++) begin
      chk($sformatf("y%0d_valid", i), longint'(out_valid), 1);
      chk($sformatf("y%0d", i), longint'(data_out), exp_y[i]);
      $display("xfer y[%0d] = %0d (expected %0d)", i, data_out, exp_y[i]);
      tick();
    end
    chk("done_pulse", longint'(done), 1);
    chk("done_out_valid", longint'(out_valid), 0);
    chk("done_busy", longint'(busy), 0);
    tick();
    chk("done_clear", longint'(done), 0);
  endtask

  task automatic set_identity();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        amat[r*N+c] = (r == c) ? 8'sd1 : 8'sd0;
    for (int i = 0; i < N; i++) xvec[i] = 8'(i + 1);
    for (int i = 0; i < M; i++) exp_y[i] = longint'(i + 1);
  endtask

  initial begin
    reset = 1'b1; load_matrix = 1'b0; load_vector = 1'b0; start = 1'b0;
    data_in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_data_out", longint'(data_out), 0);

    // start with only A loaded must be ignored
    set_identity();
    load_a(1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk("guard_busy", longint'(busy), 0);
    repeat (3) tick();
    chk("guard_busy_later", longint'(busy), 0);

    // identity, then recompute without reload
    load_x(1'b0);
    run(0);
    run(0);

    // load_matrix + start together: LOAD_M wins (64 words keep it busy)
    load_a(1'b0, 1'b1);
    run(0);

    // reload only x, A retained
    for (int i = 0; i < N; i++) xvec[i] = 8'(10 * (i + 1));
    for (int i = 0; i < M; i++) exp_y[i] = longint'(10 * (i + 1));
    load_x(1'b0);
    run(0);

    // extreme values: (-128 * -128) * 8 = 131072
    for (int k = 0; k < M*N; k++) amat[k] = 8'sh80;
    for (int i = 0; i < N; i++) xvec[i] = 8'sh80;
    for (int i = 0; i < M; i++) exp_y[i] = 131072;
    load_a(1'b0, 1'b0);
    load_x(1'b0);
    run(0);

    // gapped input plus 5 cycles of backpressure
    set_identity();
    load_a(1'b1, 1'b0);
    load_x(1'b1);
    run(5);

    // reset in the middle of COMPUTE
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    chk("mid_busy", longint'(busy), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_busy", longint'(busy), 0);
    chk("rst_mid_out_valid", longint'(out_valid), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("rst_mid_start_ignored", longint'(busy), 0);
    load_a(1'b0, 1'b0);
    load_x(1'b0);
    run(0);

    // negative row: y[0] = -8 (clamped to 0 when the ReLU is built in)
    set_identity();
    for (int c = 0; c < N; c++) amat[c] = -8'sd1;
    for (int i = 0; i < N; i++) xvec[i] = 8'sd1;
    for (int i = 0; i < M; i++) exp_y[i] = 1;
`ifdef MVM_RELU_EN
    exp_y[0] = 0;
`else
    exp_y[0] = -8;
`endif
    load_a(1'b0, 1'b0);
    load_x(1'b0);
    run(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
